// File: rtl/instr_mem_loader.sv
// Byte-stream program loader: assembles big-endian 32-bit words and writes them into
// instruction memory at stepped addresses, holding the CPU in reset for the duration of the load.
module instr_mem_loader #(
   parameter logic [31:0] BASE_ADDR = 32'd0,
   parameter logic [31:0] ADDR_STEP = 32'd4,
   parameter int unsigned MAX_WORDS = 270
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_byte,
   output logic        in_ready,
   output logic        wr_en,
   output logic [31:0] wr_addr,
   output logic [31:0] wr_data,
   output logic        cpu_hold,
   output logic        done,
   output logic        error,
   output logic [15:0] words_wr
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERROR
   } state_t;

   state_t      state;
   logic [15:0] count;
   logic [1:0]  byte_idx;
   logic        hs;
   logic [15:0] len_full;
   logic [15:0] words_next;

   assign hs         = in_valid & in_ready;
   assign len_full   = {count[15:8], in_byte};
   assign words_next = words_wr + 16'd1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         in_ready <= 1'b0;
         wr_en    <= 1'b0;
         wr_addr  <= BASE_ADDR;
         wr_data  <= 32'd0;
         cpu_hold <= 1'b0;
         done     <= 1'b0;
         error    <= 1'b0;
         words_wr <= 16'd0;
         count    <= 16'd0;
         byte_idx <= 2'd0;
      end else begin
         wr_en <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  cpu_hold <= 1'b1;
                  done     <= 1'b0;
                  error    <= 1'b0;
                  words_wr <= 16'd0;
                  wr_addr  <= BASE_ADDR;
                  in_ready <= 1'b1;
                  state    <= S_LEN_HI;
               end
            end
            S_LEN_HI: begin
               if (hs) begin
                  count[15:8] <= in_byte;
                  state       <= S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               if (hs) begin
                  count[7:0] <= in_byte;
                  // An empty or oversized image releases the CPU without touching memory
                  if (len_full == 16'd0) begin
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                     in_ready <= 1'b0;
                     state    <= S_DONE;
                  end else if ({16'd0, len_full} > 32'(MAX_WORDS)) begin
                     error    <= 1'b1;
                     cpu_hold <= 1'b0;
                     in_ready <= 1'b0;
                     state    <= S_ERROR;
                  end else begin
                     byte_idx <= 2'd0;
                     state    <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (hs) begin
                  wr_data  <= {wr_data[23:0], in_byte};
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     wr_en    <= 1'b1;
                     in_ready <= 1'b0;
                     state    <= S_WRITE;
                  end
               end
            end
            S_WRITE: begin
               words_wr <= words_next;
               wr_addr  <= wr_addr + ADDR_STEP;
               byte_idx <= 2'd0;
               if (words_next == count) begin
                  done     <= 1'b1;
                  cpu_hold <= 1'b0;
                  state    <= S_DONE;
               end else begin
                  in_ready <= 1'b1;
                  state    <= S_DATA;
               end
            end
            default: begin
               in_ready <= 1'b0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: expected writes go into a scoreboard queue,
// a negedge monitor pops and compares each wr_en pulse.
module tb_instr_mem_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_byte;
   logic        in_ready;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        cpu_hold;
   logic        done;
   logic        error;
   logic [15:0] words_wr;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;
   wr_t exp_q[$];

   instr_mem_loader dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .in_valid (in_valid),
      .in_byte  (in_byte),
      .in_ready (in_ready),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .cpu_hold (cpu_hold),
      .done     (done),
      .error    (error),
      .words_wr (words_wr)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (wr_en) begin
         if (exp_q.size() == 0) begin
            check("unexpected_wr_en", {31'd0, wr_en}, 32'd0);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_addr", wr_addr, e.addr);
            check("wr_data", wr_data, e.data);
            check("in_ready_in_write", {31'd0, in_ready}, 32'd0);
            check("cpu_hold_in_write", {31'd0, cpu_hold}, 32'd1);
         end
      end
   end

   // All drive activity happens on negedges.
   task automatic send_byte(input logic [7:0] b);
      int n;
      in_valid = 1'b1;
      in_byte  = b;
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("in_ready_timeout", 32'd0, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input bit gaps);
      for (int i = 3; i >= 0; i--) begin
         send_byte(w[i*8 +: 8]);
         if (gaps) @(negedge clk);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_header(input logic [15:0] n);
      send_byte(n[15:8]);
      send_byte(n[7:0]);
   endtask

   task automatic wait_end();
      int n;
      n = 0;
      while (!(done || error) && n < 100) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_byte  = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_wr_addr", wr_addr, 32'd0);
      check("rst_wr_data", wr_data, 32'd0);
      check("rst_flags", {28'd0, cpu_hold, done, error, wr_en}, 32'd0);
      check("rst_words_wr", {16'd0, words_wr}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Two-word frame
      push_exp(32'd0, 32'h12345678);
      push_exp(32'd4, 32'h9ABCDEF0);
      pulse_start();
      check("t1_cpu_hold", {31'd0, cpu_hold}, 32'd1);
      send_header(16'd2);
      send_word(32'h12345678, 1'b0);
      send_word(32'h9ABCDEF0, 1'b0);
      wait_end();
      check("t1_done", {31'd0, done}, 32'd1);
      check("t1_error", {31'd0, error}, 32'd0);
      check("t1_words_wr", {16'd0, words_wr}, 32'd2);
      check("t1_cpu_hold_low", {31'd0, cpu_hold}, 32'd0);
      check("t1_in_ready", {31'd0, in_ready}, 32'd0);
      check("t1_queue_empty", exp_q.size(), 32'd0);

      // Empty frame
      pulse_start();
      check("t2_done_cleared", {31'd0, done}, 32'd0);
      send_header(16'd0);
      check("t2_done", {31'd0, done}, 32'd1);
      check("t2_words_wr", {16'd0, words_wr}, 32'd0);
      check("t2_cpu_hold", {31'd0, cpu_hold}, 32'd0);

      // Oversized header, then recovery
      pulse_start();
      send_header(16'h010F);
      check("t3_error", {31'd0, error}, 32'd1);
      check("t3_done", {31'd0, done}, 32'd0);
      check("t3_in_ready", {31'd0, in_ready}, 32'd0);
      check("t3_cpu_hold", {31'd0, cpu_hold}, 32'd0);
      repeat (3) @(negedge clk);
      push_exp(32'd0, 32'hCAFEF00D);
      pulse_start();
      check("t3_error_cleared", {31'd0, error}, 32'd0);
      send_header(16'd1);
      send_word(32'hCAFEF00D, 1'b0);
      wait_end();
      check("t3_reload_done", {30'd0, done, error}, 32'd2);
      check("t3_reload_words", {16'd0, words_wr}, 32'd1);

      // Gapped stream
      push_exp(32'd0, 32'hB0000000);
      pulse_start();
      send_header(16'd1);
      send_word(32'hB0000000, 1'b1);
      wait_end();
      check("t4_done", {31'd0, done}, 32'd1);
      check("t4_queue_empty", exp_q.size(), 32'd0);

      // Reset mid-word
      pulse_start();
      send_header(16'd1);
      send_byte(8'hDE);
      send_byte(8'hAD);
      rst_n = 1'b0;
      @(negedge clk);
      check("t5_wr_addr", wr_addr, 32'd0);
      check("t5_wr_data", wr_data, 32'd0);
      check("t5_flags", {27'd0, in_ready, cpu_hold, done, error, wr_en}, 32'd0);
      check("t5_words_wr", {16'd0, words_wr}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      push_exp(32'd0, 32'h0BADBEEF);
      pulse_start();
      send_header(16'd1);
      send_word(32'h0BADBEEF, 1'b0);
      wait_end();
      check("t5_done", {31'd0, done}, 32'd1);

      // Full 270-word frame with a stray start mid-word
      for (int i = 0; i < 270; i++) push_exp(32'(i) * 32'd4, 32'hC0DE0000 + 32'(i));
      pulse_start();
      send_header(16'd270);
      for (int i = 0; i < 270; i++) begin
         if (i == 5) begin
            send_byte(8'hC0);
            send_byte(8'hDE);
            pulse_start();
            check("t6_hold_after_start", {31'd0, cpu_hold}, 32'd1);
            check("t6_done_after_start", {31'd0, done}, 32'd0);
            send_byte(8'h00);
            send_byte(8'h05);
         end else begin
            send_word(32'hC0DE0000 + 32'(i), 1'b0);
         end
      end
      wait_end();
      check("t6_done", {31'd0, done}, 32'd1);
      check("t6_words_wr", {16'd0, words_wr}, 32'd270);
      check("t6_next_addr", wr_addr, 32'd1080);
      check("t6_queue_empty", exp_q.size(), 32'd0);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
